// File: rtl/promedio_param_if.sv
`default_nettype none
// promedio_param_if: sample stream in, registered average and status out.
// Rev 1.0
interface promedio_param_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16
);
  logic             in_valid;
  logic [IN_W-1:0]  in;
  logic [OUT_W-1:0] out;
  logic             out_valid;
  logic             busy;
  logic             ovf;

  modport master (
    output in_valid, in,
    input  out, out_valid, busy, ovf
  );

  modport slave (
    input  in_valid, in,
    output out, out_valid, busy, ovf
  );
endinterface
`default_nettype wire

// File: rtl/promedio_param.sv
`default_nettype none
// promedio_param: windowed average of 2^(win_sel+4) valid samples, saturating output.
// Rev 1.0
module promedio_param #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 mode,
  input  logic                 start,
  input  logic [2:0]           win_sel,
  promedio_param_if.slave      bus
);
  localparam int ACC_W = IN_W + 11;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [ACC_W-1:0] acc;
  logic [11:0]      count;
  logic [3:0]       shift;
  logic [OUT_W-1:0] out_q;
  logic             out_valid_q;
  logic             ovf_q;

  logic [11:0]      last_idx;
  logic [3:0]       next_shift;
  logic [ACC_W-1:0] result;
  logic             sat;
  logic [OUT_W-1:0] sat_val;

  assign last_idx   = (12'd1 << shift) - 12'd1;
  assign next_shift = {1'b0, win_sel} + 4'd4;
  assign result     = acc >> shift;
  // Any bit above the output width means the average does not fit.
  assign sat        = |result[ACC_W-1:OUT_W];
  assign sat_val    = sat ? {OUT_W{1'b1}} : result[OUT_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      acc         <= '0;
      count       <= '0;
      shift       <= 4'd4;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (!en) begin
        state <= IDLE;
        acc   <= '0;
        count <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state <= ACCUM;
              acc   <= '0;
              count <= '0;
              shift <= next_shift;
            end
          end
          ACCUM: begin
            if (bus.in_valid) begin
              acc   <= acc + {{11{1'b0}}, bus.in};
              count <= count + 12'd1;
              if (count == last_idx) begin
                state <= DONE;
              end
            end
          end
          DONE: begin
            out_q       <= sat_val;
            out_valid_q <= 1'b1;
            if (sat) begin
              ovf_q <= 1'b1;
            end
            // Continuous mode restarts immediately; this cycle's sample slot is lost.
            if (mode) begin
              state <= ACCUM;
              acc   <= '0;
              count <= '0;
              shift <= next_shift;
            end else begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ovf       = ovf_q;
  assign bus.busy      = (state != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_promedio_param.sv
`default_nettype none
// tb_promedio_param: randomized + directed windows, scoreboard-checked against an arithmetic model.
// Rev 1.0
module tb_promedio_param;
  localparam int IN_W  = 16;
  localparam int OUT_W = 8;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b1;
  logic       en      = 1'b0;
  logic       mode    = 1'b0;
  logic       start   = 1'b0;
  logic [2:0] win_sel = 3'd0;

  promedio_param_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  promedio_param #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .mode    (mode),
    .start   (start),
    .win_sel (win_sel),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [OUT_W:0]   exp_q[$];
  logic             model_ovf = 1'b0;
  logic [OUT_W-1:0] model_out = '0;
  logic [OUT_W:0]   mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: truncated mean of the window, clamped to the output range, sticky overflow.
  function automatic logic [OUT_W:0] model(input longint sum, input int ws);
    longint avg;
    logic   s;
    avg = sum >> (ws + 4);
    s   = avg > longint'((1 << OUT_W) - 1);
    if (s) model_ovf = 1'b1;
    return {model_ovf, s ? {OUT_W{1'b1}} : avg[OUT_W-1:0]};
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      model_out = '0;
    end else if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("out", 32'(bus.out), 32'(mon_e[OUT_W-1:0]));
        check("ovf", 32'(bus.ovf), 32'(mon_e[OUT_W]));
        model_out = mon_e[OUT_W-1:0];
      end
    end else begin
      check("out_hold", 32'(bus.out), 32'(model_out));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_win(input int ws, input logic md);
    win_sel      = 3'(ws);
    mode         = md;
    start        = 1'b1;
    bus.in_valid = 1'b0;
    step();
    start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  // kind: 0 random 0..v, 1 constant v, 2 index. gaps: 0 none, 1 every 3rd cycle, 2 random.
  task automatic feed(input int ws, input int next_ws, input int kind, input int v,
                      input int gaps, input bit abort_done);
    longint sum = 0;
    int     n   = 1 << (ws + 4);
    int     got = 0;
    int     cyc = 0;
    while (got < n) begin
      case (gaps)
        1:       bus.in_valid = (cyc % 3) != 2;
        2:       bus.in_valid = ($urandom_range(2, 0) != 0);
        default: bus.in_valid = 1'b1;
      endcase
      case (kind)
        1:       bus.in = IN_W'(v);
        2:       bus.in = IN_W'(got);
        default: bus.in = IN_W'($urandom_range(v, 0));
      endcase
      win_sel = 3'($urandom);
      start   = 1'($urandom);
      if (bus.in_valid) begin
        sum += longint'(bus.in);
        got++;
      end
      cyc++;
      step();
    end
    win_sel      = 3'(next_ws);
    bus.in_valid = 1'($urandom);
    bus.in       = IN_W'($urandom);
    start        = 1'b0;
    if (abort_done) en = 1'b0;
    else exp_q.push_back(model(sum, ws));
    step();
    en           = 1'b1;
    bus.in_valid = 1'b0;
    if (abort_done) check("busy_after_abort", 32'(bus.busy), 32'd0);
    else check("busy_after_done", 32'(bus.busy), 32'(mode));
  endtask

  task automatic reset_check(input string name);
    check({name, "_out"}, 32'(bus.out), 32'd0);
    check({name, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({name, "_busy"}, 32'(bus.busy), 32'd0);
    check({name, "_ovf"}, 32'(bus.ovf), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in       = '0;
    #1 reset_n = 1'b0;
    en = 1'b1; start = 1'b1; mode = 1'b1; bus.in_valid = 1'b1; bus.in = 16'hFFFF; win_sel = 3'd5;
    #1 reset_check("reset_async");
    step();
    step();
    reset_check("reset_held");
    start = 1'b0; mode = 1'b0; bus.in_valid = 1'b0;
    reset_n = 1'b1;
    step();
    reset_check("after_reset");

    // One-shot constant window
    start_win(0, 1'b0);
    feed(0, 0, 1, 100, 0, 1'b0);
    step();

    // Gapped window of 0..31
    start_win(1, 1'b0);
    feed(1, 0, 2, 0, 1, 1'b0);
    step();

    // Continuous: 10s then 20s
    start_win(0, 1'b1);
    feed(0, 0, 1, 10, 0, 1'b0);
    mode = 1'b0;
    feed(0, 0, 1, 20, 0, 1'b0);
    step();

    // Abort mid-window, start held with en low must not start
    start_win(0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in       = IN_W'($urandom);
      step();
    end
    en = 1'b0; start = 1'b1;
    step();
    check("busy_after_en_low", 32'(bus.busy), 32'd0);
    start = 1'b0; en = 1'b1;
    step();
    check("busy_idle", 32'(bus.busy), 32'd0);
    start_win(0, 1'b0);
    feed(0, 0, 0, 255, 2, 1'b0);
    step();

    // Abort on the DONE edge
    start_win(0, 1'b0);
    feed(0, 0, 0, 255, 0, 1'b1);
    step();

    // Saturation then a small window
    start_win(0, 1'b0);
    feed(0, 0, 1, 300, 0, 1'b0);
    step();
    start_win(0, 1'b0);
    feed(0, 0, 1, 5, 0, 1'b0);
    step();

    // Reset mid-window discards the partial sum and clears ovf
    start_win(1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in       = IN_W'($urandom);
      step();
    end
    #2 reset_n = 1'b0;
    #1 reset_check("reset_mid");
    model_ovf = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    bus.in_valid = 1'b0;
    step();

    // Longest window
    start_win(7, 1'b0);
    feed(7, 0, 0, 511, 0, 1'b0);
    step();

    // Randomized one-shot and continuous chains
    for (int w = 0; w < 10; w++) begin
      int ws;
      int nxt;
      int len;
      int mx;
      ws  = $urandom_range(2, 0);
      len = ($urandom_range(1, 0) != 0) ? $urandom_range(3, 2) : 1;
      start_win(ws, len > 1);
      for (int k = 0; k < len; k++) begin
        nxt = $urandom_range(2, 0);
        case ($urandom_range(2, 0))
          0:       mx = 255;
          1:       mx = 400;
          default: mx = 65535;
        endcase
        if (k == len - 1) mode = 1'b0;
        feed(ws, nxt, $urandom_range(1, 0), mx, $urandom_range(2, 0), 1'b0);
        ws = nxt;
      end
      step();
    end

    step();
    step();
    check("pending_expected", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
